// File: rtl/sort_pkg.sv
// Shared types and default sizing for the sequential three-value sorter.
package sort_pkg;

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} sort_state_t;

  localparam int unsigned SORT_W = 4;
  localparam int unsigned SORT_N = 3;

endpackage

// File: rtl/cmp_swap.sv
// Single compare-exchange cell: orders a pair so the larger value lands first.
module cmp_swap #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         swapped
);

  // Strict compare keeps equal values in place, which makes the sort stable.
  always_comb begin
    swapped = (b > a);
    hi      = swapped ? b : a;
    lo      = swapped ? a : b;
  end

endmodule

// File: rtl/sort_sequencer.sv
// Loads N operands, bubble-sorts them in place through one shared cmp_swap,
// then streams them out largest-first.
module sort_sequencer
  import sort_pkg::*;
#(
  parameter int unsigned W = SORT_W,
  parameter int unsigned N = SORT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  sort_state_t   state, state_nxt;
  logic [W-1:0]  mem [N];
  logic [CW-1:0] wr_idx, cmp_idx, pass, rd_idx;
  logic [CW-1:0] cmp_nxt;
  logic [W-1:0]  hi, lo;
  logic          swapped;
  logic          in_hs, out_hs, load_done, cmp_wrap, sort_done;

  assign cmp_nxt = cmp_idx + CW'(1);

  cmp_swap #(.W(W)) u_cmp_swap (
    .a       (mem[cmp_idx]),
    .b       (mem[cmp_nxt]),
    .hi      (hi),
    .lo      (lo),
    .swapped (swapped)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Outputs are decoded from state and registers only; no input-to-output path.
  always_comb begin
    state_nxt = state;
    in_ready  = (state == LOAD) && !rst;
    out_valid = (state == DRAIN);
    out_last  = (state == DRAIN) && (rd_idx == CW'(N - 1));
    out_data  = (state == DRAIN) ? mem[rd_idx] : '0;
    busy      = (state != LOAD);
    in_hs     = in_valid && in_ready;
    out_hs    = out_valid && out_ready;
    load_done = in_hs && (wr_idx == CW'(N - 1));
    cmp_wrap  = (cmp_idx == CW'(N - 2));
    sort_done = cmp_wrap && (pass == CW'(N - 2));
    case (state)
      LOAD:    if (load_done) state_nxt = SORT;
      SORT:    if (sort_done) state_nxt = DRAIN;
      DRAIN:   if (out_hs && out_last) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) mem[i] <= '0;
      wr_idx  <= '0;
      cmp_idx <= '0;
      pass    <= '0;
      rd_idx  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_hs) begin
            mem[wr_idx] <= in_data;
            wr_idx      <= load_done ? '0 : wr_idx + CW'(1);
            if (load_done) begin
              cmp_idx <= '0;
              pass    <= '0;
            end
          end
        end
        SORT: begin
          if (swapped) begin
            mem[cmp_idx] <= hi;
            mem[cmp_nxt] <= lo;
          end
          if (cmp_wrap) begin
            cmp_idx <= '0;
            pass    <= pass + CW'(1);
          end else begin
            cmp_idx <= cmp_nxt;
          end
          if (sort_done) rd_idx <= '0;
        end
        DRAIN: begin
          if (out_hs) begin
            rd_idx <= out_last ? '0 : rd_idx + CW'(1);
            if (out_last) wr_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// Randomized and directed bench for sort_sequencer against a queue-based sorting model.
module tb_sort_sequencer;
  import sort_pkg::*;

  localparam int unsigned W = SORT_W;
  localparam int unsigned N = SORT_N;

  typedef logic [W-1:0] val_q_t[$];

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  sort_sequencer #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: repeatedly pull the largest remaining value.
  function automatic val_q_t ref_sort(input val_q_t v);
    val_q_t rem = v;
    val_q_t res = {};
    while (rem.size() > 0) begin
      int m = 0;
      for (int j = 1; j < rem.size(); j++)
        if (rem[j] > rem[m]) m = j;
      res.push_back(rem[m]);
      rem.delete(m);
    end
    return res;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'(0));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_out_last"},  32'(out_last),  32'(0));
    check({tag, "_busy"},      32'(busy),      32'(0));
    check({tag, "_out_data"},  32'(out_data),  32'(0));
  endtask

  task automatic load_values(input val_q_t v, input bit gaps);
    for (int i = 0; i < v.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = W'($urandom_range(0, 15));
          check("gap_in_ready", 32'(in_ready), 32'(1));
          step();
        end
      end
      in_valid = 1'b1;
      in_data  = v[i];
      check("ld_in_ready", 32'(in_ready), 32'(1));
      check("ld_busy", 32'(busy), 32'(0));
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_batch(input val_q_t v, input bit gaps, input int bp, input bit inj);
    val_q_t e = ref_sort(v);
    int k;
    load_values(v, gaps);
    in_valid = inj;
    in_data  = W'(12);
    k = 1;
    while (!out_valid && k < 20) begin
      check("sort_in_ready", 32'(in_ready), 32'(0));
      check("sort_busy", 32'(busy), 32'(1));
      step();
      k++;
    end
    check("latency", 32'(k), 32'(5));
    for (int i = 0; i < int'(N); i++) begin
      repeat (bp) begin
        out_ready = 1'b0;
        check("bp_out_valid", 32'(out_valid), 32'(1));
        check("bp_out_data", 32'(out_data), 32'(e[i]));
        check("bp_out_last", 32'(out_last), 32'(i == int'(N) - 1));
        check("bp_in_ready", 32'(in_ready), 32'(0));
        step();
      end
      out_ready = 1'b1;
      check("out_valid", 32'(out_valid), 32'(1));
      check("out_data", 32'(out_data), 32'(e[i]));
      check("out_last", 32'(out_last), 32'(i == int'(N) - 1));
      check("drain_in_ready", 32'(in_ready), 32'(0));
      check("drain_busy", 32'(busy), 32'(1));
      if (i == int'(N) - 1) in_valid = 1'b0;
      step();
    end
    check("post_in_ready", 32'(in_ready), 32'(1));
    check("post_out_valid", 32'(out_valid), 32'(0));
    check("post_out_data", 32'(out_data), 32'(0));
    check("post_busy", 32'(busy), 32'(0));
  endtask

  initial begin
    val_q_t v;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'(1));

    run_batch('{4'd3, 4'd9, 4'd5}, 1'b0, 0, 1'b0);
    run_batch('{4'd7, 4'd7, 4'd2}, 1'b0, 0, 1'b0);
    run_batch('{4'd0, 4'd15, 4'd15}, 1'b0, 0, 1'b0);
    run_batch('{4'd15, 4'd8, 4'd0}, 1'b0, 0, 1'b0);
    run_batch('{4'd0, 4'd8, 4'd15}, 1'b0, 0, 1'b0);
    run_batch('{4'd6, 4'd1, 4'd10}, 1'b0, 3, 1'b0);
    run_batch('{4'd4, 4'd11, 4'd1}, 1'b1, 1, 1'b1);

    // Abort a batch in its second sort cycle, then confirm a clean restart.
    load_values('{4'd9, 4'd4, 4'd6}, 1'b0);
    step();
    #2;
    rst = 1'b1;
    #1;
    check_idle("midrst");
    step();
    check_idle("midrst_hold");
    rst = 1'b0;
    #1;
    check("midrst_rel_ready", 32'(in_ready), 32'(1));
    check("midrst_rel_valid", 32'(out_valid), 32'(0));
    run_batch('{4'd1, 4'd2, 4'd3}, 1'b0, 0, 1'b0);

    for (int b = 0; b < 30; b++) begin
      v = {};
      for (int i = 0; i < int'(N); i++) v.push_back(W'($urandom_range(0, 15)));
      run_batch(v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/sort_sequencer.md
# sort_sequencer

Sequential three-value sorter controller. Accepts operands one per handshake and sorts them in place with a single shared compare-exchange unit over several cycles. Streams the result out largest-first. Sits in front of downstream consumers that need ranked values (first, second, third) but where one comparator must be time-shared instead of replicating the full combinational sorting network.

## Interface
- W, 4, operand width in bits
- N, 3, number of operands per batch (≥2); counters sized $clog2(N)
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts an operand this cycle
- in_data  input  W  operand, unsigned
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  W  sorted operand, descending order
- out_last  output  1  marks the N-th (smallest) output of a batch
- busy  output  1  high in SORT or DRAIN

## Operation
- Storage: buf[0..N-1] of W bits. Counters: wr_idx, cmp_idx, pass, rd_idx.
- States:
  - LOAD (reset state)
    - in_ready = 1 whenever rst = 0.
    - On in_valid & in_ready: buf[wr_idx] ← in_data, wr_idx++.
    - Handshake with wr_idx = N-1 → SORT, with wr_idx, cmp_idx and pass cleared.
  - SORT
    - Each cycle, cmp_swap compares buf[cmp_idx] and buf[cmp_idx+1].
    - If the second is strictly greater, the two are swapped. Equal values are not swapped, so the sort is stable.
    - cmp_idx steps 0..N-2. At wrap, pass++.
    - After pass N-2 completes (N-1 passes in total) → DRAIN with rd_idx = 0.
  - DRAIN
    - out_valid = 1, out_data = buf[rd_idx], out_last = (rd_idx == N-1).
    - On out_valid & out_ready: rd_idx++.
    - Handshake with out_last → LOAD with wr_idx = 0.
- Comparison is unsigned, W bits. No arithmetic widening.
- in_valid is ignored outside LOAD. in_data is not sampled there.
- out_data/out_valid are held stable while out_ready is low (no-drop, no-change rule).

## Timing
- Reset values, and values held while rst is asserted:
  - state = LOAD
  - all counters 0, buf all 0
  - in_ready = 0, out_valid = 0, out_last = 0, busy = 0
  - out_data = 0
- In LOAD, out_data reads 0. It is driven from buf only in DRAIN.
- Load: N cycles minimum (one operand per cycle at full in_valid).
- Sort: exactly (N-1)² cycles; 4 cycles for N = 3.
- The cycle after the last input handshake is the first SORT cycle.
- out_valid rises (N-1)² + 1 cycles after the last input handshake edge; 5 for N = 3.
- Drain: N cycles minimum. No overlap between batches: in_ready is low from the last input handshake until the cycle after the out_last handshake.
- Peak throughput for N = 3: 3 + 4 + 3 = 10 cycles per batch.
- Reset mid-operation (any state) aborts the batch immediately. No partial output after release.
- All outputs are registered or decoded purely from state/registers. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Package sort_pkg:
  - typedef enum logic [1:0] {LOAD, SORT, DRAIN} sort_state_t
  - localparam default width (4) and count (3)
- Sub-module cmp_swap, combinational:
  - inputs a, b (W bits)
  - outputs hi, lo, swapped
  - hi = (b > a) ? b : a
  - Instantiated once. It is the only comparator in the block.

## Test plan
- Basic: load 3, 9, 5 back-to-back with out_ready = 1.
  - Outputs are 9, 5, 3; out_last only on 3.
  - First out_valid 5 cycles after the last input handshake.
- Ties and stability: load 7, 7, 2 → 7, 7, 2. Load 0, 15, 15 → 15, 15, 0. No spurious swap counted for equal values.
- Extremes and order: already-descending 15, 8, 0 → 15, 8, 0. Ascending 0, 8, 15 → 15, 8, 0. Sort phase is 4 cycles in both cases.
- Backpressure:
  - During DRAIN, out_ready = 0 for 3 cycles on each output.
  - out_data and out_valid stay stable; no value is lost or repeated.
  - in_ready stays 0 until the cycle after the out_last handshake.
- Input gaps and ignore: in_valid toggles with bubbles in LOAD, and in_valid = 1 with data 12 during SORT.
  - Only LOAD handshakes are captured.
  - 12 never appears in the output.
- Reset mid-sort:
  - Assert rst in the 2nd SORT cycle; all outputs go to reset values asynchronously.
  - After release, the batch 1, 2, 3 outputs 3, 2, 1.
  - No residue from the aborted batch.
